// File: rtl/egr_dpb_pkg.sv
// Shared defaults and types for the egress dirty pointer broker.
// Optional build macro used by this block: EGR_DPB_BYPASS_EN (same-cycle push-to-pop bypass).
package egr_dpb_pkg;

  localparam int N_CH_DEF  = 4;
  localparam int PTR_W_DEF = 20;
  localparam int DEPTH_DEF = 16;
  localparam int CH_W_DEF  = $clog2(N_CH_DEF);
  localparam int CNT_W_DEF = $clog2(DEPTH_DEF) + 1;

  typedef logic [PTR_W_DEF-1:0] dpb_ptr_t;
  typedef logic [CH_W_DEF-1:0]  dpb_ch_t;
  typedef logic [CNT_W_DEF-1:0] dpb_cnt_t;

  typedef struct packed {
    logic     v;
    dpb_ch_t  ch;
    dpb_ptr_t ptr;
  } dpb_gnt_t;

endpackage

// File: rtl/egr_dpb_ch_fifo.sv
// One per-channel circular FIFO of dirty pointers with registered occupancy count.
// Storage is intentionally left out of reset; only pointers and count are cleared.
module egr_dpb_ch_fifo
  import egr_dpb_pkg::*;
#(
  parameter int PTR_W = PTR_W_DEF,
  parameter int DEPTH = DEPTH_DEF,
  parameter int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             cclk,
  input  logic             rst,
  input  logic             push,
  input  logic [PTR_W-1:0] push_ptr,
  input  logic             pop,
  output logic [PTR_W-1:0] head_ptr,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW-1:0]    PTR_ONE = AW'(1'b1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1'b1);

  logic [PTR_W-1:0] mem_r [DEPTH];
  logic [AW-1:0]    wr_ptr_r;
  logic [AW-1:0]    rd_ptr_r;
  logic [CNT_W-1:0] count_r;
  logic [CNT_W-1:0] count_nxt_s;
  logic             push_ok_s;
  logic             pop_ok_s;

  assign full      = (count_r == CNT_W'(DEPTH));
  assign empty     = (count_r == {CNT_W{1'b0}});
  assign push_ok_s = push && !full;
  assign pop_ok_s  = pop && !empty;
  assign head_ptr  = mem_r[rd_ptr_r];
  assign count     = count_r;

  // next occupancy from accepted push/pop pair
  always_comb begin
    count_nxt_s = count_r;
    case ({push_ok_s, pop_ok_s})
      2'b10:   count_nxt_s = count_r + CNT_ONE;
      2'b01:   count_nxt_s = count_r - CNT_ONE;
      default: count_nxt_s = count_r;
    endcase
  end

  // pointer and count state; power-of-2 depth makes the wrap implicit
  always_ff @(posedge cclk or posedge rst) begin
    if (rst) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      count_r  <= {CNT_W{1'b0}};
    end else begin
      if (push_ok_s) wr_ptr_r <= wr_ptr_r + PTR_ONE;
      if (pop_ok_s)  rd_ptr_r <= rd_ptr_r + PTR_ONE;
      count_r <= count_nxt_s;
    end
  end

  // entry storage write
  always_ff @(posedge cclk) begin
    if (push_ok_s) mem_r[wr_ptr_r] <= push_ptr;
  end

endmodule

// File: rtl/egr_dpb_ptr_broker.sv
// Multi-channel dirty pointer broker: per-channel FIFOs feeding registered PFS grants.
// Optional build macro: EGR_DPB_BYPASS_EN grants an empty-channel pop straight from a coincident push.
module egr_dpb_ptr_broker
  import egr_dpb_pkg::*;
#(
  parameter int N_CH  = N_CH_DEF,
  parameter int PTR_W = PTR_W_DEF,
  parameter int DEPTH = DEPTH_DEF,
  parameter int CH_W  = $clog2(N_CH),
  parameter int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic                  cclk,
  input  logic                  rst,
  input  logic                  dirty_v,
  input  logic [CH_W-1:0]       dirty_ch,
  input  logic [PTR_W-1:0]      dirty_ptr,
  output logic                  dirty_rdy,
  input  logic                  pfs_req_v,
  input  logic [CH_W-1:0]       pfs_req_ch,
  output logic                  pfs_gnt_v,
  output logic [CH_W-1:0]       pfs_gnt_ch,
  output logic [PTR_W-1:0]      pfs_gnt_ptr,
  output logic                  pfs_miss,
  output logic [N_CH*CNT_W-1:0] ch_occ,
  output logic [N_CH-1:0]       ch_empty,
  output logic                  ovf_err
);

  typedef struct packed {
    logic             v;
    logic [CH_W-1:0]  ch;
    logic [PTR_W-1:0] ptr;
  } gnt_t;

  logic [N_CH-1:0]  push_s;
  logic [N_CH-1:0]  pop_s;
  logic [N_CH-1:0]  full_s;
  logic [N_CH-1:0]  empty_s;
  logic [PTR_W-1:0] head_s [N_CH];
  logic [CNT_W-1:0] cnt_s  [N_CH];
  logic             bypass_s;
  logic             hit_s;
  gnt_t             gnt_r;
  gnt_t             gnt_nxt_s;
  logic             miss_r;
  logic             miss_nxt_s;
  logic             ovf_r;

  assign dirty_rdy = !full_s[dirty_ch];
  assign hit_s     = pfs_req_v && !empty_s[pfs_req_ch];

  // bypass only when the pop would otherwise miss on the very channel being pushed
  always_comb begin
`ifdef EGR_DPB_BYPASS_EN
    bypass_s = pfs_req_v && dirty_v && (dirty_ch == pfs_req_ch) && empty_s[pfs_req_ch];
`else
    bypass_s = 1'b0;
`endif
  end

  // per-channel push/pop strobes
  always_comb begin
    push_s = {N_CH{1'b0}};
    pop_s  = {N_CH{1'b0}};
    for (int c = 0; c < N_CH; c++) begin
      push_s[c] = dirty_v && (dirty_ch == CH_W'(c)) && !full_s[c] && !bypass_s;
      pop_s[c]  = pfs_req_v && (pfs_req_ch == CH_W'(c)) && !bypass_s;
    end
  end

  // next grant/miss; ch and ptr hold when nothing is granted
  always_comb begin
    gnt_nxt_s   = gnt_r;
    gnt_nxt_s.v = 1'b0;
    miss_nxt_s  = 1'b0;
    if (bypass_s) begin
      gnt_nxt_s.v   = 1'b1;
      gnt_nxt_s.ch  = pfs_req_ch;
      gnt_nxt_s.ptr = dirty_ptr;
    end else if (hit_s) begin
      gnt_nxt_s.v   = 1'b1;
      gnt_nxt_s.ch  = pfs_req_ch;
      gnt_nxt_s.ptr = head_s[pfs_req_ch];
    end else if (pfs_req_v) begin
      miss_nxt_s = 1'b1;
    end else begin
      miss_nxt_s = 1'b0;
    end
  end

  // grant, miss and sticky overflow registers
  always_ff @(posedge cclk or posedge rst) begin
    if (rst) begin
      gnt_r  <= '{v: 1'b0, ch: {CH_W{1'b0}}, ptr: {PTR_W{1'b0}}};
      miss_r <= 1'b0;
      ovf_r  <= 1'b0;
    end else begin
      gnt_r  <= gnt_nxt_s;
      miss_r <= miss_nxt_s;
      if (dirty_v && full_s[dirty_ch]) ovf_r <= 1'b1;
    end
  end

  for (genvar g = 0; g < N_CH; g++) begin : g_ch
    egr_dpb_ch_fifo #(
      .PTR_W (PTR_W),
      .DEPTH (DEPTH),
      .CNT_W (CNT_W)
    ) u_fifo (
      .cclk     (cclk),
      .rst      (rst),
      .push     (push_s[g]),
      .push_ptr (dirty_ptr),
      .pop      (pop_s[g]),
      .head_ptr (head_s[g]),
      .count    (cnt_s[g]),
      .full     (full_s[g]),
      .empty    (empty_s[g])
    );
    assign ch_occ[g*CNT_W +: CNT_W] = cnt_s[g];
  end

  assign ch_empty    = empty_s;
  assign pfs_gnt_v   = gnt_r.v;
  assign pfs_gnt_ch  = gnt_r.ch;
  assign pfs_gnt_ptr = gnt_r.ptr;
  assign pfs_miss    = miss_r;
  assign ovf_err     = ovf_r;

endmodule

// File: tb/tb_egr_dpb_ptr_broker.sv
// Directed bench for egr_dpb_ptr_broker: vector table plus hand sequences for fill/overflow,
// simultaneous push+pop on an empty channel (both EGR_DPB_BYPASS_EN builds) and async reset.
module tb_egr_dpb_ptr_broker;
  import egr_dpb_pkg::*;

  logic        cclk = 1'b0;
  logic        rst  = 1'b1;
  logic        dirty_v = 1'b0;
  logic [1:0]  dirty_ch = 2'd0;
  logic [19:0] dirty_ptr = 20'd0;
  logic        dirty_rdy;
  logic        pfs_req_v = 1'b0;
  logic [1:0]  pfs_req_ch = 2'd0;
  logic        pfs_gnt_v;
  logic [1:0]  pfs_gnt_ch;
  logic [19:0] pfs_gnt_ptr;
  logic        pfs_miss;
  logic [19:0] ch_occ;
  logic [3:0]  ch_empty;
  logic        ovf_err;

  int n_chk  = 0;
  int n_fail = 0;

  egr_dpb_ptr_broker dut (
    .cclk(cclk), .rst(rst),
    .dirty_v(dirty_v), .dirty_ch(dirty_ch), .dirty_ptr(dirty_ptr), .dirty_rdy(dirty_rdy),
    .pfs_req_v(pfs_req_v), .pfs_req_ch(pfs_req_ch),
    .pfs_gnt_v(pfs_gnt_v), .pfs_gnt_ch(pfs_gnt_ch), .pfs_gnt_ptr(pfs_gnt_ptr),
    .pfs_miss(pfs_miss), .ch_occ(ch_occ), .ch_empty(ch_empty), .ovf_err(ovf_err)
  );

  always #5 cclk = ~cclk;

  typedef struct {
    logic        dv;
    logic [1:0]  dch;
    logic [19:0] dptr;
    logic        rv;
    logic [1:0]  rch;
    dpb_gnt_t    egnt;
    logic        emiss;
    logic [19:0] eocc;
  } vec_t;

  vec_t vecs [15];

  function automatic logic [19:0] occ4(input int a, input int b, input int c, input int d);
    return {5'(d), 5'(c), 5'(b), 5'(a)};
  endfunction

  function automatic logic [3:0] empty_of(input logic [19:0] occ);
    logic [3:0] e;
    for (int i = 0; i < 4; i++) e[i] = (occ[i*5 +: 5] == 5'd0);
    return e;
  endfunction

  function automatic vec_t mk(input logic dv, input logic [1:0] dch, input logic [19:0] dptr,
                              input logic rv, input logic [1:0] rch, input logic gv,
                              input logic [1:0] gch, input logic [19:0] gptr, input logic miss,
                              input logic [19:0] occ);
    vec_t v;
    v.dv = dv; v.dch = dch; v.dptr = dptr; v.rv = rv; v.rch = rch;
    v.egnt.v = gv; v.egnt.ch = gch; v.egnt.ptr = gptr; v.emiss = miss; v.eocc = occ;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic step(input logic dv, input logic [1:0] dch, input logic [19:0] dp,
                      input logic rv, input logic [1:0] rch);
    dirty_v = dv; dirty_ch = dch; dirty_ptr = dp; pfs_req_v = rv; pfs_req_ch = rch;
    @(posedge cclk);
    #1;
  endtask

  initial begin
    vecs[0]  = mk(1'b1, 2'd2, 20'h00ABC, 1'b0, 2'd0, 1'b0, 2'd0, 20'h00000, 1'b0, occ4(0,0,1,0));
    vecs[1]  = mk(1'b0, 2'd0, 20'h00000, 1'b1, 2'd2, 1'b1, 2'd2, 20'h00ABC, 1'b0, occ4(0,0,0,0));
    vecs[2]  = mk(1'b0, 2'd0, 20'h00000, 1'b0, 2'd0, 1'b0, 2'd2, 20'h00ABC, 1'b0, occ4(0,0,0,0));
    vecs[3]  = mk(1'b0, 2'd0, 20'h00000, 1'b1, 2'd3, 1'b0, 2'd2, 20'h00ABC, 1'b1, occ4(0,0,0,0));
    vecs[4]  = mk(1'b1, 2'd1, 20'h00011, 1'b0, 2'd0, 1'b0, 2'd2, 20'h00ABC, 1'b0, occ4(0,1,0,0));
    vecs[5]  = mk(1'b1, 2'd1, 20'h00012, 1'b0, 2'd0, 1'b0, 2'd2, 20'h00ABC, 1'b0, occ4(0,2,0,0));
    vecs[6]  = mk(1'b1, 2'd1, 20'h00013, 1'b0, 2'd0, 1'b0, 2'd2, 20'h00ABC, 1'b0, occ4(0,3,0,0));
    vecs[7]  = mk(1'b1, 2'd1, 20'h00014, 1'b0, 2'd0, 1'b0, 2'd2, 20'h00ABC, 1'b0, occ4(0,4,0,0));
    vecs[8]  = mk(1'b1, 2'd1, 20'h00055, 1'b1, 2'd1, 1'b1, 2'd1, 20'h00011, 1'b0, occ4(0,4,0,0));
    vecs[9]  = mk(1'b0, 2'd0, 20'h00000, 1'b1, 2'd1, 1'b1, 2'd1, 20'h00012, 1'b0, occ4(0,3,0,0));
    vecs[10] = mk(1'b1, 2'd3, 20'h3AAAA, 1'b1, 2'd1, 1'b1, 2'd1, 20'h00013, 1'b0, occ4(0,2,0,1));
    vecs[11] = mk(1'b0, 2'd0, 20'h00000, 1'b1, 2'd1, 1'b1, 2'd1, 20'h00014, 1'b0, occ4(0,1,0,1));
    vecs[12] = mk(1'b0, 2'd0, 20'h00000, 1'b1, 2'd1, 1'b1, 2'd1, 20'h00055, 1'b0, occ4(0,0,0,1));
    vecs[13] = mk(1'b0, 2'd0, 20'h00000, 1'b1, 2'd1, 1'b0, 2'd1, 20'h00055, 1'b1, occ4(0,0,0,1));
    vecs[14] = mk(1'b0, 2'd0, 20'h00000, 1'b1, 2'd3, 1'b1, 2'd3, 20'h3AAAA, 1'b0, occ4(0,0,0,0));

    // reset state
    repeat (2) @(posedge cclk);
    @(negedge cclk);
    rst = 1'b0;
    #1;
    chk("rst_gnt_v", 32'(pfs_gnt_v), 32'd0);
    chk("rst_gnt_ch", 32'(pfs_gnt_ch), 32'd0);
    chk("rst_gnt_ptr", 32'(pfs_gnt_ptr), 32'd0);
    chk("rst_miss", 32'(pfs_miss), 32'd0);
    chk("rst_occ", 32'(ch_occ), 32'd0);
    chk("rst_empty", 32'(ch_empty), 32'hF);
    chk("rst_ovf", 32'(ovf_err), 32'd0);
    chk("rst_rdy", 32'(dirty_rdy), 32'd1);

    // vector table: basic grant, miss, push+pop same non-empty channel, independent channels
    for (int i = 0; i < 15; i++) begin
      step(vecs[i].dv, vecs[i].dch, vecs[i].dptr, vecs[i].rv, vecs[i].rch);
      chk($sformatf("v%0d_gnt_v", i), 32'(pfs_gnt_v), 32'(vecs[i].egnt.v));
      chk($sformatf("v%0d_gnt_ch", i), 32'(pfs_gnt_ch), 32'(vecs[i].egnt.ch));
      chk($sformatf("v%0d_gnt_ptr", i), 32'(pfs_gnt_ptr), 32'(vecs[i].egnt.ptr));
      chk($sformatf("v%0d_miss", i), 32'(pfs_miss), 32'(vecs[i].emiss));
      chk($sformatf("v%0d_occ", i), 32'(ch_occ), 32'(vecs[i].eocc));
      chk($sformatf("v%0d_empty", i), 32'(ch_empty), 32'(empty_of(vecs[i].eocc)));
      chk($sformatf("v%0d_ovf", i), 32'(ovf_err), 32'd0);
    end

    // fill ch0, overflow, drain in order across the pointer wrap
    for (int i = 0; i < 16; i++) step(1'b1, 2'd0, 20'(i), 1'b0, 2'd0);
    dirty_v = 1'b1; dirty_ch = 2'd0; dirty_ptr = 20'h00099; pfs_req_v = 1'b0;
    #1;
    chk("full_rdy", 32'(dirty_rdy), 32'd0);
    chk("full_occ0", 32'(ch_occ[4:0]), 32'd16);
    chk("full_empty0", 32'(ch_empty[0]), 32'd0);
    chk("full_ovf_pre", 32'(ovf_err), 32'd0);
    @(posedge cclk);
    #1;
    chk("ovf_set", 32'(ovf_err), 32'd1);
    chk("ovf_occ0", 32'(ch_occ[4:0]), 32'd16);
    for (int i = 0; i < 16; i++) begin
      step(1'b0, 2'd0, 20'd0, 1'b1, 2'd0);
      chk($sformatf("drain%0d_v", i), 32'(pfs_gnt_v), 32'd1);
      chk($sformatf("drain%0d_ptr", i), 32'(pfs_gnt_ptr), 32'(i));
      chk($sformatf("drain%0d_occ0", i), 32'(ch_occ[4:0]), 32'(15 - i));
    end
    step(1'b0, 2'd0, 20'd0, 1'b0, 2'd0);
    chk("drain_empty", 32'(ch_empty), 32'hF);
    chk("drain_rdy", 32'(dirty_rdy), 32'd1);
    chk("ovf_sticky", 32'(ovf_err), 32'd1);

    // simultaneous push and pop on an empty channel
    step(1'b1, 2'd0, 20'h00077, 1'b1, 2'd0);
`ifdef EGR_DPB_BYPASS_EN
    chk("byp_gnt_v", 32'(pfs_gnt_v), 32'd1);
    chk("byp_gnt_ptr", 32'(pfs_gnt_ptr), 32'h77);
    chk("byp_miss", 32'(pfs_miss), 32'd0);
    chk("byp_occ0", 32'(ch_occ[4:0]), 32'd0);
`else
    chk("nobyp_gnt_v", 32'(pfs_gnt_v), 32'd0);
    chk("nobyp_miss", 32'(pfs_miss), 32'd1);
    chk("nobyp_occ0", 32'(ch_occ[4:0]), 32'd1);
    step(1'b0, 2'd0, 20'd0, 1'b1, 2'd0);
    chk("nobyp_pop_v", 32'(pfs_gnt_v), 32'd1);
    chk("nobyp_pop_ptr", 32'(pfs_gnt_ptr), 32'h77);
    chk("nobyp_pop_occ0", 32'(ch_occ[4:0]), 32'd0);
`endif
    step(1'b0, 2'd0, 20'd0, 1'b0, 2'd0);

    // asynchronous reset with data queued and a request about to be granted
    step(1'b1, 2'd0, 20'h000A1, 1'b0, 2'd0);
    step(1'b1, 2'd1, 20'h000B1, 1'b0, 2'd0);
    step(1'b1, 2'd0, 20'h000A2, 1'b0, 2'd0);
    chk("pre_rst_occ", 32'(ch_occ), 32'(occ4(2,1,0,0)));
    dirty_v = 1'b0; pfs_req_v = 1'b1; pfs_req_ch = 2'd0;
    #3;
    rst = 1'b1;
    #1;
    chk("arst_gnt_v", 32'(pfs_gnt_v), 32'd0);
    chk("arst_gnt_ptr", 32'(pfs_gnt_ptr), 32'd0);
    chk("arst_miss", 32'(pfs_miss), 32'd0);
    chk("arst_occ", 32'(ch_occ), 32'd0);
    chk("arst_empty", 32'(ch_empty), 32'hF);
    chk("arst_ovf", 32'(ovf_err), 32'd0);
    @(posedge cclk);
    pfs_req_v = 1'b0;
    @(negedge cclk);
    rst = 1'b0;
    step(1'b0, 2'd0, 20'd0, 1'b0, 2'd0);
    chk("post_rst_gnt_v", 32'(pfs_gnt_v), 32'd0);
    chk("post_rst_miss", 32'(pfs_miss), 32'd0);
    step(1'b1, 2'd1, 20'h000C1, 1'b0, 2'd0);
    chk("post_rst_push_occ", 32'(ch_occ), 32'(occ4(0,1,0,0)));
    step(1'b0, 2'd0, 20'd0, 1'b1, 2'd1);
    chk("post_rst_gnt_v2", 32'(pfs_gnt_v), 32'd1);
    chk("post_rst_gnt_ptr", 32'(pfs_gnt_ptr), 32'hC1);
    chk("post_rst_occ2", 32'(ch_occ), 32'd0);
    step(1'b0, 2'd0, 20'd0, 1'b0, 2'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
